// File: rtl/asp_irq_aggregator.sv
// Interrupt aggregator: per-line edge/level latching, masking, and round-robin
// forwarding of one source vector at a time to the host interrupt channel.
module asp_irq_aggregator #(
    parameter int NUM_IRQ_LINES  = 4,
    parameter int CSR_DATA_WIDTH = 64,
    parameter int VEC_WIDTH      = (NUM_IRQ_LINES > 1) ? $clog2(NUM_IRQ_LINES) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_IRQ_LINES-1:0]  irq_in,
    input  logic [1:0]                csr_address,
    input  logic                      csr_read,
    input  logic                      csr_write,
    input  logic [CSR_DATA_WIDTH-1:0] csr_writedata,
    output logic [CSR_DATA_WIDTH-1:0] csr_readdata,
    output logic                      csr_readdatavalid,
    // Host channel: a request transfers on a cycle where irq_req_valid and
    // irq_req_ready are both high; once raised, valid and vector hold until then.
    output logic                      irq_req_valid,
    output logic [VEC_WIDTH-1:0]      irq_req_vector,
    input  logic                      irq_req_ready,
    output logic                      dbg_state
);

    localparam int N = NUM_IRQ_LINES;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [N-1:0]              status_q, status_d;
    logic [N-1:0]              enable_q, enable_d;
    logic [N-1:0]              mode_q, mode_d;
    logic [N-1:0]              sent_q, sent_d;
    logic [N-1:0]              irq_prev_q, irq_prev_d;
    logic [VEC_WIDTH-1:0]      rr_q, rr_d;
    logic [VEC_WIDTH-1:0]      vec_q, vec_d;
    logic [CSR_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      rvalid_q, rvalid_d;

    logic [N-1:0]              set_v;
    logic [N-1:0]              w1c_v;
    logic [N-1:0]              eligible;
    logic [N-1:0]              rotated;
    logic [N-1:0]              sent_set;
    logic                      pick_found;
    logic [VEC_WIDTH-1:0]      pick_idx;
    logic                      handshake;
    int                        pick_sum;

    generate
        if (CSR_DATA_WIDTH > N) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^csr_writedata[CSR_DATA_WIDTH-1:N];
        end
    endgenerate

    // CSR access and per-line latching; reads always see pre-write values.
    always_comb begin
        irq_prev_d = irq_in;
        set_v      = (mode_q & irq_in & ~irq_prev_q) | (~mode_q & irq_in);
        w1c_v      = (csr_write && csr_address == 2'd0) ? csr_writedata[N-1:0] : '0;
        status_d   = set_v | (status_q & ~w1c_v);
        enable_d   = (csr_write && csr_address == 2'd1) ? csr_writedata[N-1:0] : enable_q;
        mode_d     = (csr_write && csr_address == 2'd2) ? csr_writedata[N-1:0] : mode_q;

        rdata_d  = '0;
        rvalid_d = csr_read;
        if (csr_read) begin
            case (csr_address)
                2'd0: rdata_d[N-1:0] = status_q;
                2'd1: rdata_d[N-1:0] = enable_q;
                2'd2: rdata_d[N-1:0] = mode_q;
                2'd3: begin
                    rdata_d[15:8] = 8'h01;
                    rdata_d[7:0]  = 8'(NUM_IRQ_LINES);
                end
            endcase
        end
    end

    // Rotate so bit 0 is the line at rr_q, then take the lowest eligible bit.
    always_comb begin
        eligible   = status_q & enable_q & ~sent_q;
        rotated    = N'({eligible, eligible} >> rr_q);
        pick_found = 1'b0;
        pick_sum   = 0;
        for (int k = 0; k < N; k++) begin
            if (!pick_found && rotated[k]) begin
                pick_found = 1'b1;
                pick_sum   = int'(rr_q) + k;
            end
        end
        if (pick_sum >= N) begin
            pick_sum = pick_sum - N;
        end
        pick_idx = VEC_WIDTH'(pick_sum);
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        rr_d      = rr_q;
        handshake = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    vec_d   = pick_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_req_ready) begin
                    handshake = 1'b1;
                    rr_d      = (int'(vec_q) == N - 1) ? '0 : vec_q + VEC_WIDTH'(1);
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A line stays marked as forwarded until its STATUS bit is cleared.
        for (int i = 0; i < N; i++) begin
            sent_set[i] = handshake && (int'(vec_q) == i);
        end
        sent_d = (sent_q | sent_set) & status_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            status_q   <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            sent_q     <= '0;
            irq_prev_q <= '0;
            rr_q       <= '0;
            vec_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            sent_q     <= sent_d;
            irq_prev_q <= irq_prev_d;
            rr_q       <= rr_d;
            vec_q      <= vec_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign irq_req_valid     = (state_q == ST_REQ);
    assign irq_req_vector    = vec_q;
    assign csr_readdata      = rdata_q;
    assign csr_readdatavalid = rvalid_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_asp_irq_aggregator.sv
// Bench for asp_irq_aggregator: directed scenarios plus random traffic, all
// checked every cycle against a line-by-line behavioural model.
`timescale 1ns/1ps
module tb_asp_irq_aggregator;

    localparam int N  = 4;
    localparam int CW = 64;
    localparam int VW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  irq_in = '0;
    logic [1:0]    csr_address = '0;
    logic          csr_read = 1'b0;
    logic          csr_write = 1'b0;
    logic [CW-1:0] csr_writedata = '0;
    logic          irq_req_ready = 1'b0;
    logic [CW-1:0] csr_readdata;
    logic          csr_readdatavalid;
    logic          irq_req_valid;
    logic [VW-1:0] irq_req_vector;
    logic          dbg_state;

    asp_irq_aggregator #(
        .NUM_IRQ_LINES (N),
        .CSR_DATA_WIDTH(CW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .irq_in           (irq_in),
        .csr_address      (csr_address),
        .csr_read         (csr_read),
        .csr_write        (csr_write),
        .csr_writedata    (csr_writedata),
        .csr_readdata     (csr_readdata),
        .csr_readdatavalid(csr_readdatavalid),
        .irq_req_valid    (irq_req_valid),
        .irq_req_vector   (irq_req_vector),
        .irq_req_ready    (irq_req_ready),
        .dbg_state        (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
            end
        end
    endtask

    // Behavioural model state
    logic [N-1:0] m_status, m_enable, m_mode, m_sent, m_prev;
    int           m_rr, m_vec;
    bit           m_valid, m_rvalid;
    logic [63:0]  m_rdata;

    task automatic model_reset();
        m_status = '0; m_enable = '0; m_mode = '0; m_sent = '0; m_prev = '0;
        m_rr = 0; m_vec = 0; m_valid = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] st_n, hs_v;
        logic [63:0]  rv;
        bit           rise, set, clr;
        hs_v = '0;
        case (csr_address)
            2'd0:    rv = 64'(m_status);
            2'd1:    rv = 64'(m_enable);
            2'd2:    rv = 64'(m_mode);
            default: rv = 64'h100 + 64'(N);
        endcase
        m_rdata  = csr_read ? rv : 64'h0;
        m_rvalid = csr_read;
        if (m_valid) begin
            if (irq_req_ready) begin
                hs_v[m_vec] = 1'b1;
                m_rr        = (m_vec + 1) % N;
                m_valid     = 0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (m_status[idx] && m_enable[idx] && !m_sent[idx]) begin
                    m_valid = 1;
                    m_vec   = idx;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            rise    = irq_in[i] && !m_prev[i];
            set     = m_mode[i] ? rise : irq_in[i];
            clr     = csr_write && (csr_address == 2'd0) && csr_writedata[i];
            st_n[i] = set || (m_status[i] && !clr);
        end
        m_sent   = (m_sent | hs_v) & st_n;
        m_status = st_n;
        if (csr_write && csr_address == 2'd1) m_enable = csr_writedata[N-1:0];
        if (csr_write && csr_address == 2'd2) m_mode = csr_writedata[N-1:0];
        m_prev = irq_in;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            model_step();
            #1;
            check("valid", 64'(irq_req_valid), 64'(m_valid));
            check("dbg_state", 64'(dbg_state), 64'(m_valid));
            if (m_valid) check("vector", 64'(irq_req_vector), 64'(m_vec));
            check("rvalid", 64'(csr_readdatavalid), 64'(m_rvalid));
            check("rdata", csr_readdata, m_rdata);
        end
    end

    // Driver tasks: inputs change just after a falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        irq_in = '0; csr_read = 0; csr_write = 0; csr_address = '0;
        csr_writedata = '0; irq_req_ready = 0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [63:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        step();
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [63:0] d, output logic v);
        csr_address = a; csr_read = 1'b1;
        step();
        csr_read = 1'b0;
        d = csr_readdata;
        v = csr_readdatavalid;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit found;
        found = 0;
        for (int c = 0; c < budget; c++) begin
            if (irq_req_valid) begin
                found = 1;
                break;
            end
            step();
        end
        check(tag, 64'(found), 64'd1);
    endtask

    logic [63:0]   rd;
    logic          rv;
    int            cnt;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] got_q[$];
    int            r;

    initial begin
        step();
        check("reset_valid", 64'(irq_req_valid), 64'd0);
        check("reset_rvalid", 64'(csr_readdatavalid), 64'd0);
        check("reset_rdata", csr_readdata, 64'd0);
        check("reset_vector", 64'(irq_req_vector), 64'd0);
        do_reset();

        // INFO readback
        csr_rd(2'd3, rd, rv);
        check("info_valid", 64'(rv), 64'd1);
        check("info_data", rd, 64'h0000_0000_0000_0104);
        step();
        check("rdata_idle", csr_readdata, 64'd0);

        // Single level pulse on line 2
        csr_wr(2'd2, 64'h0);
        csr_wr(2'd1, 64'hF);
        irq_req_ready = 1'b1;
        irq_in = 4'h4;
        step();
        irq_in = 4'h0;
        check("t2_valid_early", 64'(irq_req_valid), 64'd0);
        step();
        check("t2_valid", 64'(irq_req_valid), 64'd1);
        check("t2_vector", 64'(irq_req_vector), 64'd2);
        step();
        check("t2_valid_drop", 64'(irq_req_valid), 64'd0);
        cnt = 0;
        repeat (10) begin
            step();
            if (irq_req_valid) cnt++;
        end
        check("t2_single_req", 64'(cnt), 64'd0);
        csr_rd(2'd0, rd, rv);
        check("t2_status", rd, 64'h4);
        csr_wr(2'd0, 64'h4);
        csr_rd(2'd0, rd, rv);
        check("t2_status_w1c", rd, 64'h0);

        // All lines at once: round-robin order from reset
        do_reset();
        csr_wr(2'd1, 64'hF);
        irq_req_ready = 1'b1;
        irq_in = 4'hF;
        step();
        irq_in = 4'h0;
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
        got_q.delete();
        repeat (30) begin
            if (irq_req_valid) got_q.push_back(irq_req_vector);
            step();
        end
        check("t3_count", 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check("t3_order", 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
        end
        csr_wr(2'd0, 64'h1);
        irq_in = 4'h1;
        step();
        irq_in = 4'h0;
        wait_valid("t3_regrant_timeout", 10);
        check("t3_regrant_vec", 64'(irq_req_vector), 64'd0);

        // Edge line 1 held high, level line 3 held high
        do_reset();
        csr_wr(2'd2, 64'h2);
        irq_in = 4'hA;
        repeat (20) step();
        csr_rd(2'd0, rd, rv);
        check("t4_status_held", rd, 64'hA);
        csr_wr(2'd0, 64'hA);
        csr_rd(2'd0, rd, rv);
        check("t4_status_w1c", rd, 64'h8);
        irq_in = 4'h8;
        step();
        irq_in = 4'hA;
        step();
        csr_rd(2'd0, rd, rv);
        check("t4_status_reedge", rd, 64'hA);
        irq_in = 4'h0;

        // Masked line becomes pending, then is unmasked
        do_reset();
        irq_req_ready = 1'b1;
        irq_in = 4'h1;
        step();
        irq_in = 4'h0;
        step();
        csr_rd(2'd0, rd, rv);
        check("t5_status", rd, 64'h1);
        check("t5_no_valid", 64'(irq_req_valid), 64'd0);
        csr_wr(2'd1, 64'h1);
        check("t5_valid_after_en", 64'(irq_req_valid), 64'd0);
        step();
        check("t5_valid_next", 64'(irq_req_valid), 64'd1);
        check("t5_vector", 64'(irq_req_vector), 64'd0);

        // Back-pressure with ENABLE cleared mid-request
        do_reset();
        csr_wr(2'd1, 64'hF);
        irq_in = 4'h2;
        step();
        irq_in = 4'h0;
        wait_valid("t6_timeout", 10);
        for (int c = 0; c < 10; c++) begin
            csr_write = (c == 2);
            csr_address = 2'd1;
            csr_writedata = 64'h0;
            step();
            check("t6_hold_valid", 64'(irq_req_valid), 64'd1);
            check("t6_hold_vec", 64'(irq_req_vector), 64'd1);
        end
        csr_write = 1'b0;
        irq_req_ready = 1'b1;
        step();
        check("t6_accept", 64'(irq_req_valid), 64'd0);
        repeat (5) step();

        // Asynchronous reset in the middle of a request
        do_reset();
        csr_wr(2'd1, 64'hF);
        irq_in = 4'h1;
        step();
        irq_in = 4'h0;
        wait_valid("t7_timeout", 10);
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_async_valid", 64'(irq_req_valid), 64'd0);
        check("t7_async_state", 64'(dbg_state), 64'd0);
        step();
        reset_n = 1'b1;
        step();
        csr_rd(2'd0, rd, rv);
        check("t7_status_lost", rd, 64'h0);

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            irq_in        = N'($urandom & $urandom);
            irq_req_ready = ($urandom_range(0, 9) < 7);
            r             = $urandom_range(0, 99);
            csr_write     = (r < 10);
            csr_read      = (r >= 5 && r < 25);
            csr_address   = 2'($urandom_range(0, 3));
            csr_writedata = {$urandom, $urandom};
            step();
        end
        irq_in = '0; csr_write = 0; csr_read = 0; irq_req_ready = 1'b1;
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
